// File: rtl/tqvp_bus_master.sv
// Initiator for the TinyQV peripheral bus: accepts single read/write commands on a
// valid/ready request channel, runs one bus access, and returns data/status on a response channel.
module tqvp_bus_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] periph_address,
    output logic [31:0]       periph_wdata,
    output logic [1:0]        periph_write_n,
    output logic [1:0]        periph_read_n,
    input  logic [31:0]       periph_rdata,
    input  logic              periph_ready,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0]  SIZE_ILLEGAL = 2'b11;
    localparam logic [1:0]  STROBE_IDLE  = 2'b11;
    localparam logic [15:0] TMO_LAST     = 16'(TIMEOUT_CYCLES - 1);

    state_t            state_reg,      state_next;
    logic [1:0]        size_reg,       size_next;
    logic [15:0]       tmo_reg,        tmo_next;
    logic [ADDR_W-1:0] addr_reg,       addr_next;
    logic [31:0]       wdata_reg,      wdata_next;
    logic [1:0]        write_n_reg,    write_n_next;
    logic [1:0]        read_n_reg,     read_n_next;
    logic [31:0]       rdata_reg,      rdata_next;
    logic              err_reg,        err_next;
    logic [7:0]        err_count_reg,  err_count_next;

    logic [31:0]       req_wdata_masked;
    logic [31:0]       periph_rdata_masked;
    logic [7:0]        err_count_inc;

    // Byte lane enables: lane 0 always, lane 1 for 16/32-bit, lanes 2-3 only for 32-bit.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic req_lane_en;
        logic rd_lane_en;
        if (gi == 0) begin : g_lane0
            assign req_lane_en = 1'b1;
            assign rd_lane_en  = 1'b1;
        end else if (gi == 1) begin : g_lane1
            assign req_lane_en = req_size[1] | req_size[0];
            assign rd_lane_en  = size_reg[1] | size_reg[0];
        end else begin : g_lane_hi
            assign req_lane_en = req_size[1];
            assign rd_lane_en  = size_reg[1];
        end
        assign req_wdata_masked[gi*8 +: 8]    = req_wdata[gi*8 +: 8]    & {8{req_lane_en}};
        assign periph_rdata_masked[gi*8 +: 8] = periph_rdata[gi*8 +: 8] & {8{rd_lane_en}};
    end

    assign err_count_inc = (err_count_reg == 8'hFF) ? err_count_reg : err_count_reg + 8'd1;

    assign req_ready      = (state_reg == IDLE) && rst_n;
    assign rsp_valid      = (state_reg == RESP);
    assign rsp_rdata      = rdata_reg;
    assign rsp_err        = err_reg;
    assign periph_address = addr_reg;
    assign periph_wdata   = wdata_reg;
    assign periph_write_n = write_n_reg;
    assign periph_read_n  = read_n_reg;
    assign err_count      = err_count_reg;

    always_comb begin
        state_next     = state_reg;
        size_next      = size_reg;
        tmo_next       = tmo_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        write_n_next   = write_n_reg;
        read_n_next    = read_n_reg;
        rdata_next     = rdata_reg;
        err_next       = err_reg;
        err_count_next = err_count_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next  = req_addr;
                    wdata_next = req_wdata_masked;
                    size_next  = req_size;
                    tmo_next   = 16'd0;
                    if (req_size == SIZE_ILLEGAL) begin
                        state_next     = RESP;
                        rdata_next     = 32'd0;
                        err_next       = 1'b1;
                        err_count_next = err_count_inc;
                    end else if (req_write) begin
                        state_next   = WRITE;
                        write_n_next = req_size;
                    end else begin
                        state_next  = READ;
                        read_n_next = req_size;
                    end
                end
            end
            WRITE: begin
                state_next   = RESP;
                write_n_next = STROBE_IDLE;
                rdata_next   = 32'd0;
                err_next     = 1'b0;
            end
            READ: begin
                // A ready in the last allowed cycle still wins over the timeout.
                if (periph_ready) begin
                    state_next  = RESP;
                    read_n_next = STROBE_IDLE;
                    rdata_next  = periph_rdata_masked;
                    err_next    = 1'b0;
                end else if (tmo_reg == TMO_LAST) begin
                    state_next     = RESP;
                    read_n_next    = STROBE_IDLE;
                    rdata_next     = 32'd0;
                    err_next       = 1'b1;
                    err_count_next = err_count_inc;
                end else begin
                    tmo_next = tmo_reg + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            size_reg      <= 2'b00;
            tmo_reg       <= 16'd0;
            addr_reg      <= '0;
            wdata_reg     <= 32'd0;
            write_n_reg   <= STROBE_IDLE;
            read_n_reg    <= STROBE_IDLE;
            rdata_reg     <= 32'd0;
            err_reg       <= 1'b0;
            err_count_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            size_reg      <= size_next;
            tmo_reg       <= tmo_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            write_n_reg   <= write_n_next;
            read_n_reg    <= read_n_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
            err_count_reg <= err_count_next;
        end
    end

endmodule
